// File: rtl/tl_cntr_param.sv
// Parametrised two-road traffic light controller with min/max green, timed
// yellow, forced hand-over on waiting traffic and a night flashing mode.
module tl_cntr_param #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GRN   = 4,
  parameter int unsigned MAX_GRN   = 20,
  parameter int unsigned YEL_CYC   = 5,
  parameter int unsigned FLASH_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       flash,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  typedef enum logic [2:0] {S_AG, S_AY, S_BG, S_BY, S_FL} state_t;

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_RED = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_GRN - 1);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_T = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] FL_T  = CNT_W'(FLASH_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;  // 0 = yellow, 1 = off

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_AG;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      S_AG: if (flash || (cnt_q >= MIN_T && !Ta) || (cnt_q >= MAX_T && Tb))
              state_d = S_AY;
      S_AY: if (cnt_q == YEL_T) state_d = flash ? S_FL : S_BG;
      S_BG: if (flash || (cnt_q >= MIN_T && !Tb) || (cnt_q >= MAX_T && Ta))
              state_d = S_BY;
      S_BY: if (cnt_q == YEL_T) state_d = flash ? S_FL : S_AG;
      S_FL: begin
        if (!flash)               state_d = S_AG;
        else if (cnt_q == FL_T)   phase_d = ~phase_q;
      end
      default: state_d = S_AG;
    endcase

    // In S_FL the dwell counter doubles as the half-period timer, so it
    // restarts at each phase toggle instead of running on to saturation.
    if (state_d != state_q) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == S_FL && cnt_q == FL_T) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    La = L_RED;
    Lb = L_RED;
    unique case (state_q)
      S_AG: La = L_GRN;
      S_AY: La = L_YEL;
      S_BG: Lb = L_GRN;
      S_BY: Lb = L_YEL;
      S_FL: begin
        La = phase_q ? L_OFF : L_YEL;
        Lb = phase_q ? L_OFF : L_YEL;
      end
      default: begin
        La = L_GRN;
        Lb = L_RED;
      end
    endcase
  end

endmodule
